// File: rtl/uart_tx.sv
// MMIO UART transmitter: byte FIFO, DATA/STAT register pair, start/8 data/stop framing.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state, state_n;
  logic [CW-1:0]   baud_cnt, cnt_n;
  logic [2:0]      bit_idx, idx_n, idx_inc;
  logic [7:0]      shreg, shreg_n;
  logic            tx_n;
  logic            pop;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            ovf;
  logic            full, empty, busy;
  logic            wr_data, wr_stat, push, ovf_set;
  logic [31:0]     stat;
  logic            unused_bits;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_data = sel & we & ~addr[2];
  assign wr_stat = sel & we & addr[2];
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push    = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;
  assign busy    = (state != S_IDLE) | ~empty;

  assign stat = {16'h0, 8'(count), 5'h0, ovf, busy, full};
  assign dout = addr[2] ? stat : 32'h0;

  assign unused_bits = ^{addr[31:3], addr[1:0], din[31:8]};

  assign idx_inc = bit_idx + 3'd1;

  always_comb begin
    state_n = state;
    cnt_n   = (baud_cnt != '0) ? baud_cnt - CW'(1) : '0;
    idx_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          state_n = S_START;
          cnt_n   = RELOAD;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (baud_cnt == '0) begin
          state_n = S_DATA;
          cnt_n   = RELOAD;
          idx_n   = 3'd0;
          tx_n    = shreg[0];
        end
      end
      S_DATA: begin
        if (baud_cnt == '0) begin
          cnt_n = RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = ^shreg;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx_inc;
            tx_n  = shreg[idx_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_cnt == '0) begin
          state_n = S_STOP;
          cnt_n   = RELOAD;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_cnt == '0) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            state_n = S_START;
            cnt_n   = RELOAD;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      baud_cnt <= cnt_n;
      bit_idx  <= idx_n;
      shreg    <= shreg_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr_stat && din[2])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push)
      mem[wr_ptr] <= din[7:0];
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of written bytes against frames decoded from tx.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame at DIV = 4.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int CLK_HZ = 4;
  localparam int BAUD   = 1;
  localparam int NBITS  = 11;
`else
  localparam int CLK_HZ = 2000;
  localparam int BAUD   = 100;
  localparam int NBITS  = 10;
`endif
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int FRAME = NBITS * DIV;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int epoch   = 0;
  int frames_seen = 0;
  int start_q[$];
  logic [7:0] sb[$];

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sel(sel), .we(we),
    .addr(addr), .din(din), .dout(dout), .tx(tx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clock);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit accept);
    if (accept) sb.push_back(b);
    bus_write(A_DATA, {24'hABCDEF, b});
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    sel = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int budget;
    budget = 20 * FRAME + 100;
    bus_read(A_STAT, s);
    while (s[1] && budget > 0) begin
      @(negedge clock);
      bus_read(A_STAT, s);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 32'd1, 32'd0);
    repeat (DIV) @(negedge clock);
  endtask

  // Frame decoder: samples each bit at its midpoint, counted from the first low negedge.
  initial begin : monitor
    int st, ep;
    logic sbit, pbit, stop;
    logic [7:0] got, exp;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        st = cyc; ep = epoch;
        frames_seen++;
        start_q.push_back(st);
        repeat (DIV / 2) @(negedge clock);
        sbit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clock);
          got[i] = tx;
        end
        pbit = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clock);
        pbit = tx;
`endif
        repeat (DIV) @(negedge clock);
        stop = tx;
        if (ep == epoch) begin
          if (sb.size() == 0) begin
            check("unexpected_frame", {24'h0, got}, 32'hFFFF_FFFF);
          end else begin
            exp = sb.pop_front();
            check("start_bit", {31'h0, sbit}, 32'h0);
            check("frame_byte", {24'h0, got}, {24'h0, exp});
            check("stop_bit", {31'h0, stop}, 32'h1);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'h0, pbit}, {31'h0, ^exp});
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] r;
    int w, s, n;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx", {31'h0, tx}, 32'h1);
    bus_read(A_STAT, r); check("rst_stat", r, 32'h0);
    bus_read(A_DATA, r); check("data_read", r, 32'h0);

    // Single byte with cycle-exact tx timing
    send(8'h55, 1'b1);
    w = cyc;
    check("pre_start_tx", {31'h0, tx}, 32'h1);
    wait_cyc(w + 1);          check("start_first", {31'h0, tx}, 32'h0);
    wait_cyc(w + DIV);        check("start_last", {31'h0, tx}, 32'h0);
    wait_cyc(w + DIV + 1);    check("bit0", {31'h0, tx}, 32'h1);
    wait_cyc(w + 2 * DIV + 1); check("bit1", {31'h0, tx}, 32'h0);
    bus_read(A_DATA, r); check("data_read_busy", r, 32'h0);
    wait_cyc(w + FRAME);      bus_read(A_STAT, r); check("busy_last", {31'h0, r[1]}, 32'h1);
    wait_cyc(w + FRAME + 1);  bus_read(A_STAT, r); check("busy_drop", {31'h0, r[1]}, 32'h0);
    check("first_start_cyc", start_q[start_q.size() - 1], w + 1);
    wait_idle();

    // Back-to-back bytes, then the parity pair
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    wait_idle();
    check("b2b_gap", start_q[start_q.size() - 1] - start_q[start_q.size() - 2], FRAME);
    send(8'h07, 1'b1);
    send(8'h03, 1'b1);
    wait_idle();
    check("b2b_gap2", start_q[start_q.size() - 1] - start_q[start_q.size() - 2], FRAME);

    // Overflow while the first frame holds the FSM
    send(8'hEE, 1'b1);
    for (int i = 0; i <= DEPTH; i++) send(8'(i), i < DEPTH);
    bus_read(A_STAT, r); check("ovf_stat", r, 32'h0000_1007);
    bus_write(A_STAT, 32'h0000_0004);
    bus_read(A_STAT, r); check("ovf_clear", r, 32'h0000_1003);
    wait_idle();
    check("sb_drained", sb.size(), 0);

    // Full FIFO with a write landing on the STOP-to-START pop edge
    send(8'h5A, 1'b1);
    w = cyc;
    for (int i = 0; i < DEPTH; i++) send(8'h80 + 8'(i), 1'b1);
    bus_read(A_STAT, r); check("full_stat", r, 32'h0000_1003);
    wait_cyc(w + 1 + FRAME - 1);
    send(8'hC3, 1'b1);
    bus_read(A_STAT, r); check("coinc_stat", r, 32'h0000_1003);
    wait_idle();
    check("sb_drained2", sb.size(), 0);

    // Reset in mid-frame with three bytes queued; a write during reset is ignored
    send(8'h00, 1'b1);
    w = cyc;
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    s = w + 1;
    wait_cyc(s + 5 * DIV - 1);
    check("pre_rst_tx", {31'h0, tx}, 32'h0);
    reset = 1'b1; sel = 1'b1; we = 1'b1; addr = A_DATA; din = 32'h99;
    epoch++;
    sb.delete();
    @(negedge clock);
    check("mid_rst_tx", {31'h0, tx}, 32'h1);
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    bus_read(A_STAT, r); check("post_rst_stat", r, 32'h0);
    n = frames_seen;
    repeat (3 * FRAME) @(negedge clock);
    check("no_frames_after_rst", frames_seen, n);
    check("idle_tx", {31'h0, tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
